// File: rtl/tmp_pkg.sv
// Shared constants and FSM state type for the temperature comparator readout
// and the sensor controller that drives it.
package tmp_pkg;

   localparam int TMP_OSR_LOG2 = 8;
   localparam int TMP_BLANK_N  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      ACCUM = 2'd2
   } tmp_state_e;

   // Blank counter must hold BLANK_N; keep at least one bit when BLANK_N is 0.
   function automatic int blank_cnt_width(input int blank_n);
      return (blank_n < 1) ? 1 : $clog2(blank_n + 1);
   endfunction

endpackage

// File: rtl/tmp_readout_acc.sv
// Window accumulator: counts comparator samples and ones, flags the sample
// that completes a 2^OSR_LOG2 window and self-clears on that sample.
module tmp_readout_acc
   import tmp_pkg::*;
#(
   parameter int OSR_LOG2 = TMP_OSR_LOG2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                sample,
   input  logic                cmp,
   output logic [OSR_LOG2:0]   ones_total,
   output logic                window_done
);

   localparam int RES_W = OSR_LOG2 + 1;
   localparam logic [OSR_LOG2-1:0] SAMPLE_TC = OSR_LOG2'(1);

   logic [OSR_LOG2-1:0] sample_cnt;
   logic [RES_W-1:0]    ones_cnt;

   // Down-counter starting at 0: it wraps on the first sample, so the value 1
   // is seen exactly on the 2^OSR_LOG2-th sample of the window.
   always_comb begin
      ones_total  = ones_cnt + RES_W'(cmp);
      window_done = sample && (sample_cnt == SAMPLE_TC);
   end

   always_ff @(posedge clk) begin
      if (reset || clear || window_done) begin
         sample_cnt <= '0;
         ones_cnt   <= '0;
      end else if (sample) begin
         sample_cnt <= sample_cnt - SAMPLE_TC;
         ones_cnt   <= ones_total;
      end
   end

endmodule

// File: rtl/tmp_readout.sv
// Comparator readout: blanks the first samples after enable, accumulates
// windows of 2^OSR_LOG2 comparator decisions and hands results to a consumer.
//
//   state | meaning
//   IDLE  | disabled; counters cleared, strobes ignored
//   BLANK | discarding the first BLANK_N strobes after enable rise
//   ACCUM | counting samples/ones; windows repeat back to back
module tmp_readout
   import tmp_pkg::*;
#(
   parameter  int OSR_LOG2 = TMP_OSR_LOG2,
   parameter  int BLANK_N  = TMP_BLANK_N,
   localparam int RES_W    = OSR_LOG2 + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             cmp,
   input  logic             cmp_strobe,
   output logic [RES_W-1:0] data_o,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             busy,
   output logic             overrun
);

   localparam int              BLK_W      = blank_cnt_width(BLANK_N);
   localparam logic [BLK_W-1:0] BLANK_LOAD = BLK_W'(BLANK_N);
   localparam logic [BLK_W-1:0] BLANK_TC   = BLK_W'(1);

   tmp_state_e       state_q;
   tmp_state_e       state_d;
   logic [BLK_W-1:0] blank_cnt;
   logic             blank_done;
   logic             acc_clear;
   logic             acc_sample;
   logic             window_done;
   logic             xfer;
   logic [RES_W-1:0] ones_total;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = (BLANK_N == 0) ? ACCUM : BLANK;
         BLANK: begin
            if (!enable)         state_d = IDLE;
            else if (blank_done) state_d = ACCUM;
         end
         ACCUM:   if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A completing strobe is accepted even with enable low so the result is
   // still delivered on the way back to IDLE.
   always_comb begin
      busy       = (state_q != IDLE);
      acc_clear  = (state_q == IDLE);
      acc_sample = (state_q == ACCUM) && cmp_strobe;
      blank_done = (state_q == BLANK) && cmp_strobe && (blank_cnt == BLANK_TC);
      xfer       = data_valid && data_ready;
   end

   always_ff @(posedge clk) begin
      if (reset)                                blank_cnt <= '0;
      else if (state_q == IDLE)                 blank_cnt <= BLANK_LOAD;
      else if (state_q == BLANK && cmp_strobe)  blank_cnt <= blank_cnt - BLANK_TC;
   end

   tmp_readout_acc #(
      .OSR_LOG2 (OSR_LOG2)
   ) u_acc (
      .clk         (clk),
      .reset       (reset),
      .clear       (acc_clear),
      .sample      (acc_sample),
      .cmp         (cmp),
      .ones_total  (ones_total),
      .window_done (window_done)
   );

   // Overwrite of an unconsumed result flags overrun; a transfer in the same
   // cycle as a new result counts as consumed, so it clears instead.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_o     <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end else if (window_done) begin
         data_o     <= ones_total;
         data_valid <= 1'b1;
         if (data_valid && !xfer) overrun <= 1'b1;
         else if (xfer)           overrun <= 1'b0;
      end else if (xfer) begin
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tmp_readout.sv
// Directed and randomized bench for tmp_readout (OSR_LOG2=4, BLANK_N=2)
// against a queue-based window model.
module tb_tmp_readout;

   localparam int OSR_LOG2 = 4;
   localparam int BLANK_N  = 2;
   localparam int RES_W    = OSR_LOG2 + 1;
   localparam int WIN      = 1 << OSR_LOG2;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b0;
   logic             cmp = 1'b0;
   logic             cmp_strobe = 1'b0;
   logic             data_ready = 1'b0;
   logic [RES_W-1:0] data_o;
   logic             data_valid;
   logic             busy;
   logic             overrun;

   int checks = 0;
   int errors = 0;

   // Model: session flag, blanks consumed, samples of the open window.
   bit m_active;
   int m_blanks;
   int m_win[$];
   int m_data;
   bit m_valid;
   bit m_ovr;

   always #5 clk = ~clk;

   tmp_readout #(
      .OSR_LOG2 (OSR_LOG2),
      .BLANK_N  (BLANK_N)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .cmp        (cmp),
      .cmp_strobe (cmp_strobe),
      .data_o     (data_o),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .busy       (busy),
      .overrun    (overrun)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_tick();
      bit deliver;
      bit xfer;
      int res;
      deliver = 1'b0;
      res     = 0;
      if (reset) begin
         m_active = 1'b0;
         m_blanks = 0;
         m_win.delete();
         m_data  = 0;
         m_valid = 1'b0;
         m_ovr   = 1'b0;
         return;
      end
      if (!m_active) begin
         if (enable) begin
            m_active = 1'b1;
            m_blanks = 0;
            m_win.delete();
         end
      end else begin
         if (cmp_strobe) begin
            if (m_blanks < BLANK_N) m_blanks++;
            else begin
               m_win.push_back(int'(cmp));
               if (m_win.size() == WIN) begin
                  deliver = 1'b1;
                  res     = m_win.sum();
                  m_win.delete();
               end
            end
         end
         if (!enable) m_active = 1'b0;
      end
      xfer = m_valid && data_ready;
      if (deliver) begin
         if (m_valid && !xfer) m_ovr = 1'b1;
         else if (xfer)        m_ovr = 1'b0;
         m_data  = res;
         m_valid = 1'b1;
      end else if (xfer) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
   endtask

   task automatic step(input logic en, input logic stb, input logic c, input logic rdy);
      enable     = en;
      cmp_strobe = stb;
      cmp        = c;
      data_ready = rdy;
      @(posedge clk);
      model_tick();
      #1;
      chk("data_o",     32'(data_o),     32'(m_data));
      chk("data_valid", 32'(data_valid), 32'(m_valid));
      chk("busy",       32'(busy),       32'(m_active));
      chk("overrun",    32'(overrun),    32'(m_ovr));
   endtask

   // One window of WIN strobes, the first n_ones carrying cmp=1.
   task automatic window(input int n_ones, input logic rdy);
      for (int i = 0; i < WIN; i++) step(1'b1, 1'b1, 1'(i < n_ones), rdy);
   endtask

   initial begin
      logic en_r;

      // Reset, with strobes that must be ignored
      reset = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("reset_data",  32'(data_o),     32'd0);
      chk("reset_busy",  32'(busy),       32'd0);
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // 18 strobes of ones: two blanked, result 16 one cycle after the last
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < BLANK_N + WIN; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("full_scale",   32'(data_o),     32'd16);
      chk("full_valid",   32'(data_valid), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("full_consumed", 32'(data_valid), 32'd0);

      // Alternating window, then all-zero window, no re-blanking
      for (int i = 0; i < WIN; i++) step(1'b1, 1'b1, 1'(i % 2 == 0), 1'b1);
      chk("alt_half", 32'(data_o), 32'd8);
      window(0, 1'b1);
      chk("all_zero",  32'(data_o),     32'd0);
      chk("zero_valid", 32'(data_valid), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b1);

      // Two windows unconsumed: overwrite and overrun, then one ready pulse
      window(5, 1'b0);
      window(11, 1'b0);
      chk("ovr_data", 32'(data_o),  32'd11);
      chk("ovr_flag", 32'(overrun), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("ovr_cleared", 32'(overrun),    32'd0);
      chk("ovr_drained", 32'(data_valid), 32'd0);

      // New result loading in the same cycle as a transfer
      window(16, 1'b0);
      for (int i = 0; i < WIN - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("xfer_load_valid", 32'(data_valid), 32'd1);
      chk("xfer_load_ovr",   32'(overrun),    32'd0);
      chk("xfer_load_data",  32'(data_o),     32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b1);

      // Abort after 7 samples, re-enable: re-blank, partial excluded
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("abort_idle", 32'(busy), 32'd0);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      window(3, 1'b1);
      chk("reblank_data", 32'(data_o), 32'd3);
      step(1'b1, 1'b0, 1'b0, 1'b1);

      // Window-completing strobe with enable dropping
      for (int i = 0; i < WIN - 1; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("drop_deliver", 32'(data_o),     32'd15);
      chk("drop_valid",   32'(data_valid), 32'd1);
      chk("drop_idle",    32'(busy),       32'd0);

      // Reset mid-window with a pending result
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
      reset = 1'b1;
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("rst_valid", 32'(data_valid), 32'd0);
      chk("rst_busy",  32'(busy),       32'd0);
      chk("rst_data",  32'(data_o),     32'd0);
      reset = 1'b0;

      // Randomized traffic
      en_r = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(79) == 0) en_r = ~en_r;
         reset = ($urandom_range(399) == 0);
         step(en_r, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(2) == 0);
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tmp_readout.md
TMP_READOUT -- requirements
Module: tmp_readout

Interface
REQ-001 Parameter OSR_LOG2, default 8, log2 of comparator samples per conversion window.
REQ-002 Parameter BLANK_N, default 2, number of comparator samples discarded after each enable rise.
REQ-003 Derived width RES_W = OSR_LOG2+1, the result width; it holds the full-scale value 2^OSR_LOG2.
REQ-004 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  level; 1 = run conversions, 0 = abort and idle.
REQ-007 cmp  input  1  comparator decision from the sensor controller.
REQ-008 cmp_strobe  input  1  one-cycle pulse; cmp is valid in that cycle.
REQ-009 data_o  output  RES_W  count of cmp=1 samples in the last completed window.
REQ-010 data_valid  output  1  data_o holds an unconsumed result.
REQ-011 data_ready  input  1  consumer accepts data_o when high with data_valid.
REQ-012 busy  output  1  high in states BLANK and ACCUM.
REQ-013 overrun  output  1  sticky; a result was overwritten before it was consumed.

Function
REQ-014 FSM states: IDLE, BLANK, ACCUM.
REQ-015 IDLE: when enable=1 -> BLANK (or ACCUM if BLANK_N=0) next cycle; sample counter and ones counter cleared; cmp_strobe ignored.
REQ-016 BLANK: each cmp_strobe increments the blank counter; the strobe that makes it BLANK_N -> ACCUM, and that sample is not accumulated.
REQ-017 ACCUM: each cmp_strobe increments the sample counter and adds cmp to the ones counter.
REQ-018 On the strobe that brings the sample count to 2^OSR_LOG2, data_o SHALL load the ones count including that sample, visible with data_valid=1 on the next cycle (latency 1).
REQ-019 After a window completes, both counters clear in the same cycle and ACCUM continues with no re-blanking while enable=1.
REQ-020 All-ones window: data_o = 2^OSR_LOG2 (MSB set). All-zeros window: data_o = 0. No wrap.
REQ-021 enable=0 in BLANK or ACCUM -> IDLE next cycle; the partial window is discarded; data_o, data_valid and overrun are unaffected.
REQ-022 enable=0 in the same cycle as a window-completing strobe: the result is still delivered, then IDLE.
REQ-023 Transfer occurs when data_valid and data_ready are both 1; data_valid clears next cycle unless a new result loads in the same cycle.
REQ-024 New result while data_valid=1 and no transfer that cycle: data_o is overwritten, data_valid stays 1, overrun is set.
REQ-025 New result and transfer in the same cycle: the new data loads, data_valid stays 1, overrun is not set.
REQ-026 overrun clears on the cycle after a transfer with no simultaneous new overrun event; an overrun event takes priority over a clear.
REQ-027 data_o SHALL stay stable while data_valid=1 except on overwrite per REQ-024.
REQ-028 data_ready while data_valid=0 has no effect.

Reset
REQ-029 On reset=1: state IDLE; all counters 0; data_o=0, data_valid=0, busy=0, overrun=0.
REQ-030 Reset mid-window or with a pending result discards everything; after reset release, operation starts from IDLE per REQ-015.

Structure
REQ-031 Package tmp_pkg SHALL hold the FSM state enum (IDLE/BLANK/ACCUM) and the default OSR_LOG2/BLANK_N constants shared with the sensor controller.
REQ-032 One sub-module, tmp_readout_acc (sample counter + ones counter with clear and terminal-count flag), is natural; the FSM and output register stay in the top module.

Verification (OSR_LOG2=4, BLANK_N=2)
REQ-033 enable=1, 18 strobes with cmp=1, data_ready=1 -> first 2 discarded; data_o=16 (0x10) and data_valid pulses 1 cycle after the 18th strobe.
REQ-034 Blanking done, then 16 strobes with alternating cmp 1,0,... -> data_o=8; the next window of all cmp=0 -> data_o=0 with no re-blanking.
REQ-035 data_ready=0 across two windows (5 ones, then 11 ones) -> data_o=11, overrun=1; a single data_ready pulse then gives data_valid=0 and overrun=0.
REQ-036 data_ready=1 on the same cycle a new result loads -> data_valid stays 1, overrun stays 0.
REQ-037 enable dropped after 7 ACCUM strobes, re-raised -> 2 blank strobes, then a fresh 16-sample count; the 7 partial samples are excluded.
REQ-038 reset asserted mid-window with data_valid=1 -> all outputs 0 next cycle; strobes during reset are ignored.
